// File: rtl/pwm_pkg.sv
// Shared constants and capture FSM state type for the PWM capture block.
package pwm_pkg;

  localparam int DUTY_W       = 7;
  localparam int DUTY_MAX_DEF = 100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// Sequential duty divider: floor(high*DUTY_MAX/period), one quotient bit per cycle, MSB first.
// o_done is asserted during the last iteration and o_duty is valid in that same cycle.
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [CNT_W-1:0]  i_high,
  input  logic [CNT_W:0]    i_period,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_duty
);

  localparam int           W     = CNT_W + DUTY_W + 1;
  localparam logic [W-1:0] SCALE = W'(DUTY_MAX);

  logic [W-1:0]        r_rem;
  logic [W-1:0]        r_dvs;
  logic [DUTY_W-2:0]   r_quot;
  logic [2:0]          r_bit;
  logic                r_busy;
  logic                w_ge;
  logic [W-1:0]        w_dividend;

  assign w_dividend = W'(i_high) * SCALE;
  assign w_ge       = (r_rem >= r_dvs);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= 1'b0;
      r_bit  <= '0;
    end else if (i_abort) begin
      r_busy <= 1'b0;
    end else if (i_start && !r_busy) begin
      r_busy <= 1'b1;
      r_bit  <= 3'(DUTY_W - 1);
    end else if (r_busy) begin
      r_bit <= r_bit - 3'd1;
      if (r_bit == 3'd0) r_busy <= 1'b0;
    end
  end

  // Divisor starts pre-shifted to the quotient MSB and walks right each cycle
  always_ff @(posedge clk) begin
    if (i_start && !r_busy) begin
      r_rem  <= w_dividend;
      r_dvs  <= W'(i_period) << (DUTY_W - 1);
      r_quot <= '0;
    end else if (r_busy) begin
      if (w_ge) r_rem <= r_rem - r_dvs;
      r_dvs  <= r_dvs >> 1;
      r_quot <= {r_quot[DUTY_W-3:0], w_ge};
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_busy && (r_bit == 3'd0);
  assign o_duty = {r_quot, w_ge};

endmodule

// File: rtl/pwm_capture.sv
// PWM period/duty capture with 2-flop synchronizer, IDLE/HIGH/LOW phase FSM and timeout.
// Optional 3-sample glitch filter on the synchronized input: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DUTY_MAX = DUTY_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_out,
  output logic [CNT_W:0]    period_out,
  output logic              valid,
  output logic              timeout
);

  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [DUTY_W-1:0] DMAX    = DUTY_W'(DUTY_MAX);

  logic              r_sync1, r_sync2, r_s_d;
  logic              w_s, w_rise, w_fall;
  cap_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_high, r_low, w_high_nxt, w_low_nxt;
  logic              w_close, w_to_evt, w_start;
  logic [CNT_W:0]    w_period_sum, r_per_lat;
  logic              w_div_busy, w_div_done;
  logic [DUTY_W-1:0] w_div_duty;
  logic              r_valid, r_timeout;
  logic [DUTY_W-1:0] r_duty;
  logic [CNT_W:0]    r_period;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] r_hist;
  logic       r_filt;

  // Output follows the input combinationally once three samples agree, which keeps the delay at 2 cycles
  assign w_s = (r_sync2 == r_hist[0] && r_hist[0] == r_hist[1]) ? r_sync2 : r_filt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hist <= '0;
      r_filt <= 1'b0;
    end else begin
      r_hist <= {r_hist[0], r_sync2};
      r_filt <= w_s;
    end
  end
`else
  assign w_s = r_sync2;
`endif

  assign w_rise       = w_s & ~r_s_d;
  assign w_fall       = ~w_s & r_s_d;
  assign w_period_sum = {1'b0, r_high} + {1'b0, r_low};
  assign w_start      = w_close && !w_div_busy;

  always_comb begin
    w_state_nxt = r_state;
    w_high_nxt  = r_high;
    w_low_nxt   = r_low;
    w_close     = 1'b0;
    w_to_evt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rise) begin
          w_state_nxt = HIGH;
          w_high_nxt  = CNT_W'(1);
          w_low_nxt   = '0;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_state_nxt = LOW;
          w_low_nxt   = CNT_W'(1);
        end else if (r_high == CNT_MAX) begin
          w_to_evt    = 1'b1;
          w_state_nxt = IDLE;
          w_high_nxt  = '0;
          w_low_nxt   = '0;
        end else begin
          w_high_nxt = sat_inc(r_high);
        end
      end
      LOW: begin
        // The cycle of the closing edge already belongs to the next high phase
        if (w_rise) begin
          w_close     = 1'b1;
          w_state_nxt = HIGH;
          w_high_nxt  = CNT_W'(1);
          w_low_nxt   = '0;
        end else if (r_low == CNT_MAX) begin
          w_to_evt    = 1'b1;
          w_state_nxt = IDLE;
          w_high_nxt  = '0;
          w_low_nxt   = '0;
        end else begin
          w_low_nxt = sat_inc(r_low);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_high  <= '0;
      r_low   <= '0;
      r_s_d   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_high  <= w_high_nxt;
      r_low   <= w_low_nxt;
      r_s_d   <= w_s;
    end
  end

  always_ff @(posedge clk) begin
    if (w_start) r_per_lat <= w_period_sum;
  end

  pwm_duty_div #(
    .CNT_W    (CNT_W),
    .DUTY_MAX (DUTY_MAX)
  ) u_div (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_abort  (w_to_evt),
    .i_high   (r_high),
    .i_period (w_period_sum),
    .o_busy   (w_div_busy),
    .o_done   (w_div_done),
    .o_duty   (w_div_duty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_duty    <= '0;
      r_period  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (w_to_evt) begin
        r_valid   <= 1'b1;
        r_timeout <= 1'b1;
        r_period  <= '0;
        r_duty    <= w_s ? DMAX : '0;
      end else begin
        if (w_rise) r_timeout <= 1'b0;
        if (w_div_done && !r_timeout) begin
          r_valid  <= 1'b1;
          r_duty   <= w_div_duty;
          r_period <= r_per_lat;
        end
      end
    end
  end

  assign valid      = r_valid;
  assign timeout    = r_timeout;
  assign duty_out   = r_duty;
  assign period_out = r_period;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: stimulus queues expected results, a negedge monitor checks each valid.
module tb_pwm_capture;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int FLT = 2;
`else
  localparam int FLT = 0;
`endif
  localparam int LAT = 10 + FLT;

  typedef struct {
    int period;
    int duty;
    int at;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        pwm_in;
  logic [6:0]  duty_out;
  logic [16:0] period_out;
  logic        valid;
  logic        timeout;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  pwm_capture #(.CNT_W(16), .DUTY_MAX(100)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic v, input int n);
    pwm_in = v;
    repeat (n) step();
  endtask

  task automatic push(input int p, input int d, input int at);
    exp_q.push_back('{p, d, at});
  endtask

  task automatic rst_pulse(input int n);
    reset = 1'b0;
    #1;
    chk("rst_duty_out", int'(duty_out), 0);
    chk("rst_period_out", int'(period_out), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    repeat (n) step();
    reset = 1'b1;
  endtask

  // Monitor: every valid strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (reset === 1'b1 && valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: actual period_out=%0d duty_out=%0d, required no valid (cycle %0d)",
                 period_out, duty_out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.at);
        chk("period_out", int'(period_out), e.period);
        chk("duty_out", int'(duty_out), e.duty);
      end
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: actual cycle=%0d required finish before limit", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    reset  = 1'b0;
    pwm_in = 1'b0;
    step();
    rst_pulse(3);

    // 64 high / 192 low: the first rising edge only opens the measurement
    phase(1'b1, 64);
    phase(1'b0, 192);
    repeat (3) begin
      push(256, 25, cyc + LAT);
      phase(1'b1, 64);
      phase(1'b0, 192);
    end

    // Reset at cycle 100 of a period, then a full post-reset period is needed
    push(256, 25, cyc + LAT);
    phase(1'b1, 64);
    phase(1'b0, 36);
    rst_pulse(3);
    phase(1'b0, 153);
    phase(1'b1, 64);
    phase(1'b0, 192);
    push(256, 25, cyc + LAT);
    phase(1'b1, 64);
    phase(1'b0, 192);

    // Reset while the division is running: no result may appear
    phase(1'b1, 6);
    rst_pulse(2);
    phase(1'b0, 20);

    // 200 high / 56 low -> 78
    phase(1'b1, 200);
    phase(1'b0, 56);
    push(256, 78, cyc + LAT);
    phase(1'b1, 200);
    phase(1'b0, 56);
    rst_pulse(2);

    // 1 high / 2 low: closing edges during a division are dropped
    phase(1'b1, 1);
    phase(1'b0, 2);
    for (int k = 1; k <= 9; k++) begin
      if (FLT == 0 && (k % 3) == 1) push(3, 33, cyc + LAT);
      phase(1'b1, 1);
      phase(1'b0, 2);
    end
    phase(1'b0, 20);
    rst_pulse(2);

    // 2-cycle glitch inside the low phase
    phase(1'b1, 64);
    phase(1'b0, 50);
    if (FLT == 0) push(114, 56, cyc + LAT);
    phase(1'b1, 2);
    phase(1'b0, 140);
    if (FLT == 0) push(142, 1, cyc + LAT);
    else          push(256, 25, cyc + LAT);
    phase(1'b1, 64);
    phase(1'b0, 20);
    rst_pulse(2);

    // Held high beyond the counter range -> timeout
    t0 = cyc;
    push(0, 100, t0 + 2 + FLT + 65536);
    phase(1'b1, 70000);
    chk("timeout_set", int'(timeout), 1);
    chk("timeout_period_hold", int'(period_out), 0);
    chk("timeout_duty_hold", int'(duty_out), 100);
    phase(1'b0, 10);
    chk("timeout_still_set", int'(timeout), 1);
    phase(1'b1, 8);
    chk("timeout_cleared", int'(timeout), 0);
    phase(1'b0, 5);
    rst_pulse(2);

    repeat (5) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
